// File: rtl/mips_cpu_muldiv_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mips_cpu_muldiv_if : request/result bundle between control/regfile and     |
// |                      the HI/LO multiply-divide unit.                       |
// | Revision 1.0                                                               |
// +-----------------------------------------------------------------------------+
interface mips_cpu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, funct, opa, opb,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, funct, opa, opb,
    output busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/mips_cpu_muldiv.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mips_cpu_muldiv : iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus    |
// |                   MTHI/MTLO. Optional MULDIV_FAST_MULT_EN: 1-cycle multiply.|
// | Revision 1.0                                                               |
// +-----------------------------------------------------------------------------+
module mips_cpu_muldiv #(
  parameter int WIDTH = 32
) (
  input wire clk,
  input wire rst,
  mips_cpu_muldiv_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic               op_mul, op_div, op_sgn, b_zero;
  logic               opa_neg, opb_neg;
  logic [WIDTH-1:0]   opa_mag, opb_mag;
  logic [WIDTH:0]     mul_sum, rem_sh, rem_sub;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    op_mul = (bus.funct == F_MULT) || (bus.funct == F_MULTU);
    op_div = (bus.funct == F_DIV)  || (bus.funct == F_DIVU);
    op_sgn = (bus.funct == F_MULT) || (bus.funct == F_DIV);
    b_zero = (bus.opb == '0);
    // A zero divisor runs unsigned on the raw dividend so HI comes back as opa.
    opa_neg = op_sgn && bus.opa[WIDTH-1] && !(op_div && b_zero);
    opb_neg = op_sgn && bus.opb[WIDTH-1] && !(op_div && b_zero);
    opa_mag = opa_neg ? (~bus.opa + 1'b1) : bus.opa;
    opb_mag = opb_neg ? (~bus.opb + 1'b1) : bus.opb;
  end

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    rem_sh   = {rem_q, a_q[WIDTH-1]};
    rem_sub  = rem_sh - {1'b0, b_q};
    prod_fix = neg_q  ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = neg_q  ? (~a_q + 1'b1)   : a_q;
    rem_fix  = rneg_q ? (~rem_q + 1'b1) : rem_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    acc_d    = acc_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (op_mul || op_div) begin
            a_d      = opa_mag;
            b_d      = opb_mag;
            is_div_d = op_div;
            neg_d    = opa_neg ^ opb_neg;
            rneg_d   = opa_neg;
            rem_d    = '0;
            acc_d    = {{WIDTH{1'b0}}, opb_mag};
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = S_RUN;
`ifdef MULDIV_FAST_MULT_EN
            if (op_mul) begin
              acc_d   = {{WIDTH{1'b0}}, opa_mag} * {{WIDTH{1'b0}}, opb_mag};
              state_d = S_FIX;
            end
`else
`endif
          end else if (bus.funct == F_MTHI) begin
            hi_d = bus.opa;
          end else if (bus.funct == F_MTLO) begin
            lo_d = bus.opa;
          end
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          // Restoring step: quotient bits shift into a_q as dividend bits leave.
          if (!rem_sub[WIDTH]) begin
            rem_d = rem_sub[WIDTH-1:0];
            a_d   = {a_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[WIDTH-1:0];
            a_d   = {a_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_muldiv.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_mips_cpu_muldiv : directed-vector bench for mips_cpu_muldiv.            |
// | Revision 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_mips_cpu_muldiv;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_BUSY = 1;
`else
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_BUSY = 33;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  mips_cpu_muldiv_if #(.WIDTH(32)) bus ();
  mips_cpu_muldiv #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Launch at the current negedge and return at the negedge where done must be high.
  task automatic run_op(input string tag, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int ebusy, input int poke);
    logic [31:0] h0, l0;
    int nb;
    bit bad;
    nb = 0;
    bad = 1'b0;
    h0 = bus.hi;
    l0 = bus.lo;
    bus.start = 1'b1; bus.funct = fn; bus.opa = a; bus.opb = b;
    @(negedge clk);
    bus.start = 1'b0; bus.opa = 32'hDEADBEEF; bus.opb = 32'h0BADF00D;
    while (bus.busy && nb < 100) begin
      nb++;
      if (bus.done || bus.hi !== h0 || bus.lo !== l0) bad = 1'b1;
      if (poke != 0 && nb == poke) begin
        bus.start = 1'b1; bus.funct = F_MULTU; bus.opa = 32'd3; bus.opb = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, " busy cycles"}, nb, ebusy);
    check({tag, " hold while busy"}, {31'b0, bad}, 32'd0);
    check({tag, " done"}, {31'b0, bus.done}, 32'd1);
    check({tag, " hi"}, bus.hi, ehi);
    check({tag, " lo"}, bus.lo, elo);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, " done one cycle"}, {31'b0, bus.done}, 32'd0);
    check({tag, " busy low"}, {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    bus.start = 1'b0; bus.funct = 6'd0; bus.opa = '0; bus.opb = '0;
    repeat (2) @(negedge clk);
    check("reset busy", {31'b0, bus.busy}, 32'd0);
    check("reset done", {31'b0, bus.done}, 32'd0);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // MTHI then MTLO on consecutive edges
    bus.start = 1'b1; bus.funct = F_MTHI; bus.opa = 32'h12345678;
    @(negedge clk);
    check("mthi hi", bus.hi, 32'h12345678);
    check("mthi lo", bus.lo, 32'd0);
    check("mthi busy", {31'b0, bus.busy}, 32'd0);
    check("mthi done", {31'b0, bus.done}, 32'd0);
    bus.funct = F_MTLO; bus.opa = 32'h9ABCDEF0;
    @(negedge clk);
    check("mtlo lo", bus.lo, 32'h9ABCDEF0);
    check("mtlo hi", bus.hi, 32'h12345678);
    check("mtlo busy", {31'b0, bus.busy}, 32'd0);
    check("mtlo done", {31'b0, bus.done}, 32'd0);
    bus.start = 1'b0;
    @(negedge clk);

    // Unsupported funct is ignored
    bus.start = 1'b1; bus.funct = 6'b100000; bus.opa = 32'h1; bus.opb = 32'h2;
    @(negedge clk);
    bus.start = 1'b0;
    check("ignored funct busy", {31'b0, bus.busy}, 32'd0);
    check("ignored funct hi", bus.hi, 32'h12345678);
    check("ignored funct lo", bus.lo, 32'h9ABCDEF0);

    run_op("multu max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_BUSY, 0);
    idle_check("multu max");
    run_op("mult -3*5", F_MULT, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, MUL_BUSY, 0);
    run_op("div -7/2 b2b", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_BUSY, 0);
    idle_check("div -7/2");
    run_op("divu 7/2", F_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, DIV_BUSY, 0);
    idle_check("divu 7/2");
    run_op("divu by zero", F_DIVU, 32'h64, 32'd0, 32'h64, 32'hFFFFFFFF, DIV_BUSY, 0);
    idle_check("divu by zero");
    run_op("div by zero", F_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, DIV_BUSY, 0);
    run_op("div min/-1", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, DIV_BUSY, 0);
    run_op("mult -2*-3", F_MULT, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd0, 32'd6, MUL_BUSY, 0);
    run_op("div 7/-2", F_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, DIV_BUSY, 0);
    run_op("divu 100/7 poked", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_BUSY, 5);
    idle_check("divu 100/7 poked");

    // Abort mid-operation with reset
    seen = 1'b0;
    bus.start = 1'b1; bus.funct = F_DIVU; bus.opa = 32'd100; bus.opb = 32'd7;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      bus.start = (c == 5);
      if (c == 5) begin bus.funct = F_MULTU; bus.opa = 32'd3; bus.opb = 32'd3; end
      rst = (c == 10);
    end
    check("abort busy", {31'b0, bus.busy}, 32'd0);
    check("abort hi", bus.hi, 32'd0);
    check("abort lo", bus.lo, 32'd0);
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("abort no done", {31'b0, seen}, 32'd0);
    check("abort hi held", bus.hi, 32'd0);
    run_op("divu 100/7", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_BUSY, 0);
    idle_check("divu 100/7");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
